exc_commit_ctrl: RTL and testbench

- Precise-exception and CP0 controller at the write-back boundary of the 5-stage MIPS pipeline.
- Samples the committing WB instruction's exception, eret and mtc0 attributes, and updates CP0 state (Status, Cause, EPC, BadVAddr, Count, Compare).
- Issues a one-cycle registered pipeline flush with a redirect PC.
- Presents a registered interrupt-pending flag to ID, so the next decoded instruction can be tagged with an interrupt.

---
 rtl/exc_commit_ctrl_pkg.sv | 37 +++
 rtl/exc_commit_ctrl_timer.sv | 64 ++++++
 rtl/exc_commit_ctrl.sv | 168 ++++++++++++++++
 tb/tb_exc_commit_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_commit_ctrl_pkg.sv
// ============================================================================
// Module      : exc_commit_ctrl_pkg
// Description : Shared CP0 addresses, ExcCode values and commit FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exc_commit_ctrl_pkg;

    // CP0 addresses are {rd[4:0], sel[2:0]}
    localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } commit_state_t;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

`default_nettype wire

// File: rtl/exc_commit_ctrl_timer.sv
// ============================================================================
// Module      : cp0_timer
// Description : CP0 Count/Compare timer with TI flag; present only when
//               CP0_TIMER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef CP0_TIMER_EN
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;
    logic [31:0] w_count_next;
    logic        w_count_upd;

    // Count advances on the odd phase of the tick; a software load overrides it.
    always_comb begin
        w_count_upd  = count_we | r_tick;
        w_count_next = r_count;
        if (count_we)
            w_count_next = wdata;
        else if (r_tick)
            w_count_next = r_count + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick    <= 1'b0;
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else begin
            r_tick  <= ~r_tick;
            r_count <= w_count_next;
            if (compare_we)
                r_compare <= wdata;
            // A Compare write always wins over a simultaneous match.
            if (compare_we)
                r_ti <= 1'b0;
            else if (w_count_upd && (w_count_next == r_compare))
                r_ti <= 1'b1;
        end
    end

    assign count   = r_count;
    assign compare = r_compare;
    assign ti      = r_ti;

endmodule
`endif

`default_nettype wire

// File: rtl/exc_commit_ctrl.sv
// ============================================================================
// Module      : exc_commit_ctrl
// Description : Precise-exception / CP0 controller at WB commit. Build macro
//               CP0_TIMER_EN enables the Count/Compare timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter int          CP0_ADDR_WD = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ws_valid,
    input  logic [31:0]            ws_pc,
    input  logic                   ws_exc_valid,
    input  logic [4:0]             ws_exc_code,
    input  logic                   ws_is_slot,
    input  logic [31:0]            ws_badvaddr,
    input  logic                   ws_eret,
    input  logic                   ws_mtc0_we,
    input  logic [CP0_ADDR_WD-1:0] ws_cp0_addr,
    input  logic [31:0]            ws_cp0_wdata,
    output logic [31:0]            cp0_rdata,
    input  logic [5:0]             ext_int_in,
    output logic                   flush,
    output logic [31:0]            flush_pc,
    output logic                   int_pending
);

    commit_state_t r_state;
    commit_state_t w_state_next;

    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip_hw;
    logic [1:0]  r_cause_ip_sw;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] r_flush_pc;
    logic        r_int_pending;

    logic        w_commit;
    logic        w_exc_commit;
    logic        w_eret_commit;
    logic        w_mtc0_commit;
    logic [7:0]  w_ip;
    logic        w_int_pending_next;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;

    assign w_commit      = ws_valid && (r_state == ST_RUN);
    assign w_exc_commit  = w_commit && ws_exc_valid;
    assign w_eret_commit = w_commit && !ws_exc_valid && ws_eret;
    assign w_mtc0_commit = w_commit && !ws_exc_valid && !ws_eret && ws_mtc0_we;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (w_mtc0_commit && (ws_cp0_addr == CP0_COUNT)),
        .compare_we (w_mtc0_commit && (ws_cp0_addr == CP0_COMPARE)),
        .wdata      (ws_cp0_wdata),
        .count      (w_count),
        .compare    (w_compare),
        .ti         (w_ti)
    );
`else
    assign w_count   = 32'd0;
    assign w_compare = 32'd0;
    assign w_ti      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_RUN;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:   if (w_exc_commit || w_eret_commit) w_state_next = ST_FLUSH;
            ST_FLUSH: w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    assign w_ip = {r_cause_ip_hw, r_cause_ip_sw};

    // Suppressed on flushing commits so the request never precedes visible EXL.
    assign w_int_pending_next = (w_exc_commit || w_eret_commit) ? 1'b0 :
                                (r_status_ie && !r_status_exl && |(w_ip & r_status_im));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_status_im   <= 8'd0;
            r_status_exl  <= 1'b0;
            r_status_ie   <= 1'b0;
            r_cause_bd    <= 1'b0;
            r_cause_ip_hw <= 6'd0;
            r_cause_ip_sw <= 2'd0;
            r_cause_exc   <= 5'd0;
            r_epc         <= 32'd0;
            r_badvaddr    <= 32'd0;
            r_flush_pc    <= 32'd0;
            r_int_pending <= 1'b0;
        end else begin
            r_cause_ip_hw <= {w_ti | ext_int_in[5], ext_int_in[4:0]};
            r_int_pending <= w_int_pending_next;
            if (w_exc_commit) begin
                if (!r_status_exl) begin
                    r_epc      <= ws_is_slot ? (ws_pc - 32'd4) : ws_pc;
                    r_cause_bd <= ws_is_slot;
                end
                r_status_exl <= 1'b1;
                r_cause_exc  <= ws_exc_code;
                if (is_addr_exc(ws_exc_code))
                    r_badvaddr <= ws_badvaddr;
                r_flush_pc <= EXC_VECTOR;
            end else if (w_eret_commit) begin
                r_status_exl <= 1'b0;
                r_flush_pc   <= r_epc;
            end else if (w_mtc0_commit) begin
                case (ws_cp0_addr)
                    CP0_STATUS: begin
                        r_status_im  <= ws_cp0_wdata[15:8];
                        r_status_exl <= ws_cp0_wdata[1];
                        r_status_ie  <= ws_cp0_wdata[0];
                    end
                    CP0_CAUSE: r_cause_ip_sw <= ws_cp0_wdata[9:8];
                    CP0_EPC:   r_epc         <= ws_cp0_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        case (ws_cp0_addr)
            CP0_BADVADDR: cp0_rdata = r_badvaddr;
            CP0_COUNT:    cp0_rdata = w_count;
            CP0_COMPARE:  cp0_rdata = w_compare;
            CP0_STATUS:   cp0_rdata = {9'd0, 1'b1, 6'd0, r_status_im, 6'd0,
                                       r_status_exl, r_status_ie};
            CP0_CAUSE:    cp0_rdata = {r_cause_bd, w_ti, 14'd0, r_cause_ip_hw,
                                       r_cause_ip_sw, 1'b0, r_cause_exc, 2'd0};
            CP0_EPC:      cp0_rdata = r_epc;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    assign flush       = (r_state == ST_FLUSH);
    assign flush_pc    = r_flush_pc;
    assign int_pending = r_int_pending;

endmodule

`default_nettype wire

// File: tb/tb_exc_commit_ctrl.sv
// ============================================================================
// Module      : tb_exc_commit_ctrl
// Description : Directed self-checking bench; flush targets are scoreboarded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exc_commit_ctrl;

    localparam logic [7:0] A_BADV = 8'h40;
    localparam logic [7:0] A_CNT  = 8'h48;
    localparam logic [7:0] A_CMP  = 8'h58;
    localparam logic [7:0] A_STAT = 8'h60;
    localparam logic [7:0] A_CAUS = 8'h68;
    localparam logic [7:0] A_EPC  = 8'h70;
    localparam logic [31:0] VEC   = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ws_valid = 1'b0;
    logic [31:0] ws_pc = 32'd0;
    logic        ws_exc_valid = 1'b0;
    logic [4:0]  ws_exc_code = 5'd0;
    logic        ws_is_slot = 1'b0;
    logic [31:0] ws_badvaddr = 32'd0;
    logic        ws_eret = 1'b0;
    logic        ws_mtc0_we = 1'b0;
    logic [7:0]  ws_cp0_addr = 8'd0;
    logic [31:0] ws_cp0_wdata = 32'd0;
    logic [31:0] cp0_rdata;
    logic [5:0]  ext_int_in = 6'd0;
    logic        flush;
    logic [31:0] flush_pc;
    logic        int_pending;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic        r_prev_flush = 1'b0;

    exc_commit_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .ws_valid     (ws_valid),
        .ws_pc        (ws_pc),
        .ws_exc_valid (ws_exc_valid),
        .ws_exc_code  (ws_exc_code),
        .ws_is_slot   (ws_is_slot),
        .ws_badvaddr  (ws_badvaddr),
        .ws_eret      (ws_eret),
        .ws_mtc0_we   (ws_mtc0_we),
        .ws_cp0_addr  (ws_cp0_addr),
        .ws_cp0_wdata (ws_cp0_wdata),
        .cp0_rdata    (cp0_rdata),
        .ext_int_in   (ext_int_in),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .int_pending  (int_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every flush must be one cycle wide and match the oldest expected target.
    always @(negedge clk) begin
        if (flush) begin
            chk("flush_width", {31'd0, r_prev_flush}, 32'd0);
            chk("flush_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0)
                chk("flush_pc", flush_pc, exp_q.pop_front());
        end
        r_prev_flush <= flush;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
        ws_cp0_addr = a;
        #1;
        chk(tag, cp0_rdata, exp);
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        ws_valid = 1'b1; ws_mtc0_we = 1'b1; ws_cp0_addr = a; ws_cp0_wdata = d;
        step();
        ws_valid = 1'b0; ws_mtc0_we = 1'b0;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc,
                       input logic slot, input logic [31:0] badv);
        ws_valid = 1'b1; ws_exc_valid = 1'b1; ws_exc_code = code;
        ws_pc = pc; ws_is_slot = slot; ws_badvaddr = badv;
        exp_q.push_back(VEC);
        step();
        ws_valid = 1'b0; ws_exc_valid = 1'b0; ws_is_slot = 1'b0;
    endtask

    initial begin
        logic [31:0] cause;
        int n;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_flush_pc", flush_pc, 32'd0);
        chk("rst_int_pending", {31'd0, int_pending}, 32'd0);
        chk_reg("rst_status", A_STAT, 32'h00400000);
        chk_reg("rst_cause", A_CAUS, 32'd0);
        chk_reg("rst_epc", A_EPC, 32'd0);
        chk_reg("rst_badv", A_BADV, 32'd0);

        // Syscall, not in a slot
        exc(5'd8, 32'hBFC00100, 1'b0, 32'hDEAD0000);
        chk("sys_flush_now", {31'd0, flush}, 32'd1);
        step();
        chk("sys_flush_gone", {31'd0, flush}, 32'd0);
        chk_reg("sys_epc", A_EPC, 32'hBFC00100);
        chk_reg("sys_cause", A_CAUS, 32'h00000020);
        chk_reg("sys_status", A_STAT, 32'h00400002);
        chk_reg("sys_badv_kept", A_BADV, 32'd0);

        // AdEL in a delay slot
        mtc0(A_STAT, 32'd0);
        exc(5'd4, 32'h80000014, 1'b1, 32'h00000003);
        step();
        chk_reg("adel_epc", A_EPC, 32'h80000010);
        chk_reg("adel_cause", A_CAUS, 32'h80000010);
        chk_reg("adel_badv", A_BADV, 32'h00000003);

        // Nested exception with EXL already set
        exc(5'd12, 32'h80000200, 1'b0, 32'h12345678);
        step();
        chk_reg("nest_epc", A_EPC, 32'h80000010);
        chk_reg("nest_cause", A_CAUS, 32'h80000030);
        chk_reg("nest_badv", A_BADV, 32'h00000003);

        // eret, with a commit during FLUSH that must be ignored
        mtc0(A_EPC, 32'h80000040);
        ws_valid = 1'b1; ws_eret = 1'b1;
        exp_q.push_back(32'h80000040);
        step();
        ws_eret = 1'b0; ws_exc_valid = 1'b1; ws_exc_code = 5'd9; ws_pc = 32'h00001234;
        chk("eret_flush_now", {31'd0, flush}, 32'd1);
        step();
        ws_valid = 1'b0; ws_exc_valid = 1'b0;
        step();
        chk_reg("eret_status", A_STAT, 32'h00400000);
        chk_reg("eret_cause", A_CAUS, 32'h80000030);
        chk_reg("eret_epc", A_EPC, 32'h80000040);

        // Interrupt pending masking and latency
        mtc0(A_STAT, 32'h00000401);
        chk_reg("im_status", A_STAT, 32'h00400401);
        mtc0(A_CAUS, 32'h00000100);
        step(); step();
        chk("ip0_masked", {31'd0, int_pending}, 32'd0);
        ext_int_in = 6'b000001;
        step(); step();
        chk("hw2_pending", {31'd0, int_pending}, 32'd1);
        chk_reg("hw2_cause", A_CAUS, 32'h80000530);
        ext_int_in = 6'd0;
        step(); step();
        chk("hw2_dropped", {31'd0, int_pending}, 32'd0);
        mtc0(A_STAT, 32'h00000101);
        chk("sw0_latency", {31'd0, int_pending}, 32'd0);
        step();
        chk("sw0_pending", {31'd0, int_pending}, 32'd1);
        mtc0(A_STAT, 32'h00000103);
        step();
        chk("exl_masks", {31'd0, int_pending}, 32'd0);
        mtc0(A_STAT, 32'h00000101);
        step();
        chk("sw0_again", {31'd0, int_pending}, 32'd1);
        exc(5'd0, 32'h80000300, 1'b0, 32'd0);
        chk("exc_forces_low", {31'd0, int_pending}, 32'd0);
        step();
        chk("exc_exl_low", {31'd0, int_pending}, 32'd0);
        chk_reg("int_epc", A_EPC, 32'h80000300);
        mtc0(A_CAUS, 32'd0);
        mtc0(A_STAT, 32'd0);

`ifdef CP0_TIMER_EN
        mtc0(A_STAT, 32'h00008001);
        mtc0(A_CMP, 32'd5);
        mtc0(A_CNT, 32'd0);
        n = 0;
        ws_cp0_addr = A_CAUS;
        #1;
        cause = cp0_rdata;
        while (!cause[30] && n < 20) begin
            step();
            ws_cp0_addr = A_CAUS;
            #1;
            cause = cp0_rdata;
            n++;
        end
        chk("ti_set", {31'd0, cause[30]}, 32'd1);
        chk("ti_latency", {31'd0, (n >= 8) && (n <= 11)}, 32'd1);
        chk_reg("ti_count", A_CNT, 32'd5);
        step(); step();
        chk("ti_pending", {31'd0, int_pending}, 32'd1);
        mtc0(A_CMP, 32'd100);
        chk_reg("ti_cleared", A_CAUS, 32'h00008000);
        chk_reg("cmp_rd", A_CMP, 32'd100);
        mtc0(A_STAT, 32'd0);
`else
        mtc0(A_CNT, 32'h00000055);
        mtc0(A_CMP, 32'h00000066);
        chk_reg("no_timer_count", A_CNT, 32'd0);
        chk_reg("no_timer_compare", A_CMP, 32'd0);
        chk_reg("no_timer_ti", A_CAUS, 32'd0);
`endif
        mtc0(8'h08, 32'hFFFFFFFF);
        chk_reg("unmapped", 8'h08, 32'd0);

        // Reset while flushing
        exc(5'd10, 32'h80000500, 1'b0, 32'd0);
        chk("pre_reset_flush", {31'd0, flush}, 32'd1);
        reset = 1'b1;
        step();
        chk("reset_drops_flush", {31'd0, flush}, 32'd0);
        chk("reset_flush_pc", flush_pc, 32'd0);
        reset = 1'b0;
        step();
        chk("reset_stays_run", {31'd0, flush}, 32'd0);
        chk_reg("reset_status", A_STAT, 32'h00400000);

        step();
        chk("flush_q_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
